sorter_bist: RTL and testbench
==============================

Name: sorter_bist

Overview:
- Built-in self-test engine for the 4-input, 2-bit sorter.
- Sweeps all 256 packed input patterns into the sorter and samples the sorter outputs for each one.
- Checks each result for sort order and for being a permutation of the inputs; counts failures and reports pass/fail.
- Sits beside the sorter instance: drives its in0..in3 and consumes its out0..out3, so the sorter can be exercised on-chip without a bench.

Parameters:
- SETTLE, 1: cycles the pattern is held before outputs are sampled (covers sorter latency); legal range 0..15.
- DESCENDING, 0: 0 = expect out0<=out1<=out2<=out3; 1 = expect out0>=out1>=out2>=out3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- pat_out  output  8  current pattern to sorter: in0=pat_out[7:6], in1=[5:4], in2=[3:2], in3=[1:0].
- dut_out0  input  2  sorter out0.
- dut_out1  input  2  sorter out1.
- dut_out2  input  2  sorter out2.
- dut_out3  input  2  sorter out3.
- busy  output  1  high while a sweep is running.
- done  output  1  high in DONE until the next start or reset.
- pass  output  1  valid while done; 1 iff err_count==0.
- err_count  output  9  number of failing patterns, 0..256.
- first_err_valid  output  1  set at the first failing pattern of a sweep.
- first_err_pat  output  8  pattern of the first failure; 0 when first_err_valid=0.

Behaviour:
- Reset (async, immediate) forces:
  - state=IDLE;
  - pat_out=0, busy=0, done=0, pass=0, err_count=0;
  - first_err_valid=0, first_err_pat=0;
  - settle counter=0.
- State IDLE:
  - start -> DRIVE next cycle.
  - On that transition: pat_out=0, settle counter=SETTLE, err_count=0, first_err cleared, busy=1.
- State DRIVE:
  - pat_out held stable.
  - Counter nonzero: decrement and stay.
  - Counter zero: go to CHECK.
- State CHECK (exactly one cycle), evaluates dut_out0..3 sampled this cycle:
  - Order check: adjacent comparisons per DESCENDING.
  - Permutation check: per-value (0..3) occurrence counts over in0..in3 equal those over dut_out0..3.
  - Fail = order check fails OR permutation check fails.
  - On fail: err_count += 1. If first_err_valid=0, capture first_err_pat=pat_out and set first_err_valid=1.
  - If pat_out==8'hFF -> DONE. Otherwise pat_out += 1, counter=SETTLE, -> DRIVE.
- Timing:
  - Each pattern occupies SETTLE+1 cycles in DRIVE plus 1 cycle in CHECK.
  - A sweep takes 256*(SETTLE+2) cycles from the first DRIVE cycle to DONE entry.
- State DONE:
  - busy=0, done=1, pass=(err_count==0).
  - pat_out remains 8'hFF; results hold.
  - start -> same actions as from IDLE: results cleared, new sweep.
- Boundary rules:
  - start while busy is ignored.
  - pat_out never wraps: the sweep ends after 8'hFF.
  - err_count saturation is not needed; its maximum of 256 fits in 9 bits.
  - Reset mid-sweep aborts immediately to the reset values; no partial results are kept.
  - start asserted in the same cycle as rst: reset wins.
- All outputs are registered; no combinational path from dut_out* to any output.

Test Plan:
- Correct ascending sorter model, SETTLE=1, DESCENDING=0, pulse start:
  - busy for 768 cycles, then done=1, pass=1, err_count=0, first_err_valid=0.
- Identity DUT (out_i=in_i), DESCENDING=0:
  - Only the 35 nondecreasing patterns pass.
  - err_count=221, first_err_valid=1, first_err_pat=8'h04, pass=0.
- DUT outputs stuck at 0:
  - Permutation fails for every pattern except 8'h00.
  - err_count=255, first_err_pat=8'h01.
- Correct ascending sorter with DESCENDING=1:
  - Only the all-equal patterns 00/55/AA/FF pass.
  - err_count=252, first_err_pat=8'h01.
- Assert rst at pattern 8'h40 mid-sweep:
  - All outputs return to reset values immediately.
  - A new start gives a full clean sweep with correct totals.
- Pulse start while busy (at pattern 8'h10):
  - No effect; sweep completes once with the same totals as an unperturbed run.
- start in DONE:
  - err_count and first_err clear, then the sweep reruns.

Source files
------------

// File: rtl/sorter_bist.sv
// sorter_bist: built-in self-test engine for a 4-input, 2-bit sorter.
// It drives all 256 packed input patterns and waits SETTLE cycles after each
// one. It then checks the sorter outputs for sort order and for being a
// permutation of the inputs. It counts the failing patterns and records the
// first one. Every output is registered.
module sorter_bist #(
    parameter int unsigned SETTLE     = 1,    // hold cycles before sampling, 0..15
    parameter bit          DESCENDING = 1'b0  // 0: ascending order expected
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] pat_out,
    input  logic [1:0] dut_out0,
    input  logic [1:0] dut_out1,
    input  logic [1:0] dut_out2,
    input  logic [1:0] dut_out3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       first_err_valid,
    output logic [7:0] first_err_pat
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;

    logic [1:0] in_vals  [4];
    logic [1:0] out_vals [4];
    logic [2:0] cnt_in   [4];
    logic [2:0] cnt_out  [4];
    logic       order_ok;
    logic       perm_ok;
    logic       fail;

    // State register; reset aborts any sweep at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. start is only honoured in IDLE and DONE, so it is ignored while busy.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DRIVE;
            DRIVE:   if (settle_cnt == 4'd0) state_next = CHECK;
            CHECK:   state_next = (pat_out == 8'hFF) ? DONE : DRIVE;
            DONE:    if (start) state_next = DRIVE;
            default: state_next = IDLE;
        endcase
    end

    // Result check on the sampled sorter outputs: order, then per-value occurrence counts.
    always_comb begin
        in_vals[0]  = pat_out[7:6];
        in_vals[1]  = pat_out[5:4];
        in_vals[2]  = pat_out[3:2];
        in_vals[3]  = pat_out[1:0];
        out_vals[0] = dut_out0;
        out_vals[1] = dut_out1;
        out_vals[2] = dut_out2;
        out_vals[3] = dut_out3;
        for (int v = 0; v < 4; v++) begin
            cnt_in[v]  = 3'd0;
            cnt_out[v] = 3'd0;
        end
        for (int i = 0; i < 4; i++) begin
            cnt_in[in_vals[i]]   = cnt_in[in_vals[i]] + 3'd1;
            cnt_out[out_vals[i]] = cnt_out[out_vals[i]] + 3'd1;
        end
        perm_ok = 1'b1;
        for (int v = 0; v < 4; v++) begin
            if (cnt_in[v] != cnt_out[v]) perm_ok = 1'b0;
        end
        order_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (DESCENDING) begin
                if (out_vals[i] < out_vals[i+1]) order_ok = 1'b0;
            end else begin
                if (out_vals[i] > out_vals[i+1]) order_ok = 1'b0;
            end
        end
        fail = !(order_ok && perm_ok);
    end

    // Sweep datapath: pattern counter, settle counter, error tally and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_out         <= 8'h00;
            settle_cnt      <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 9'd0;
            first_err_valid <= 1'b0;
            first_err_pat   <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat_out         <= 8'h00;
                        settle_cnt      <= SETTLE_CNT;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 9'd0;
                        first_err_valid <= 1'b0;
                        first_err_pat   <= 8'h00;
                    end
                end
                DRIVE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (fail) begin
                        err_count <= err_count + 9'd1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_pat   <= pat_out;
                        end
                    end
                    if (pat_out == 8'hFF) begin
                        // Last pattern: pass must include this final verdict.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !fail && (err_count == 9'd0);
                    end else begin
                        pat_out    <= pat_out + 8'd1;
                        settle_cnt <= SETTLE_CNT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_bist.sv
// tb_sorter_bist: drives two BIST instances (ascending SETTLE=1, descending SETTLE=2)
// against a behavioural sorter whose behaviour is selected per sweep: correct,
// identity, stuck-at-zero, or a random mix of sorted and garbage outputs.
module tb_sorter_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_d;
    logic [7:0] pat_a, pat_d;
    logic [7:0] mo_a, mo_d;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_d, done_d, pass_d, fv_d;
    logic [8:0] err_a, err_d;
    logic [7:0] fp_a, fp_d;

    int checks = 0;
    int errors = 0;
    int mode_a = 0;
    int mode_d = 0;
    longint t_a0, t_d0;

    logic [7:0] tbl_rnd [256];
    bit         tbl_sel [256];

    always #5 clk = ~clk;

    sorter_bist #(.SETTLE(1), .DESCENDING(1'b0)) u_asc (
        .clk(clk), .rst(rst), .start(start_a), .pat_out(pat_a),
        .dut_out0(mo_a[7:6]), .dut_out1(mo_a[5:4]), .dut_out2(mo_a[3:2]), .dut_out3(mo_a[1:0]),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_valid(fv_a), .first_err_pat(fp_a)
    );

    sorter_bist #(.SETTLE(2), .DESCENDING(1'b1)) u_desc (
        .clk(clk), .rst(rst), .start(start_d), .pat_out(pat_d),
        .dut_out0(mo_d[7:6]), .dut_out1(mo_d[5:4]), .dut_out2(mo_d[3:2]), .dut_out3(mo_d[1:0]),
        .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
        .first_err_valid(fv_d), .first_err_pat(fp_d)
    );

    // Ascending sort of the four 2-bit fields, done on a plain int array.
    function automatic logic [7:0] sort_asc(input logic [7:0] p);
        int v [4];
        int t;
        for (int i = 0; i < 4; i++) v[i] = int'(p[7-2*i -: 2]);
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        return {v[0][1:0], v[1][1:0], v[2][1:0], v[3][1:0]};
    endfunction

    // Behavioural sorter under test: 0 correct, 1 identity, 2 stuck zero, 3 random mix.
    function automatic logic [7:0] model_out(input int mode, input logic [7:0] p);
        case (mode)
            0:       return sort_asc(p);
            1:       return p;
            2:       return 8'h00;
            default: return tbl_sel[p] ? sort_asc(p) : tbl_rnd[p];
        endcase
    endfunction

    // The sorter has one cycle of latency, which SETTLE covers.
    always @(posedge clk) begin
        mo_a <= model_out(mode_a, pat_a);
        mo_d <= model_out(mode_d, pat_d);
    end

    // Reference verdict for a whole sweep: sorted-multiset equality plus order over every pattern.
    task automatic ref_sweep(input int mode, input bit desc, output int n,
                             output logic [7:0] fp, output bit fv);
        logic [7:0] o;
        int ov [4];
        bit bad;
        n = 0; fp = 8'h00; fv = 1'b0;
        for (int p = 0; p < 256; p++) begin
            o = model_out(mode, 8'(p));
            for (int i = 0; i < 4; i++) ov[i] = int'(o[7-2*i -: 2]);
            bad = (sort_asc(8'(p)) != sort_asc(o));
            for (int i = 0; i < 3; i++)
                if (desc ? (ov[i] < ov[i+1]) : (ov[i] > ov[i+1])) bad = 1'b1;
            if (bad) begin
                n++;
                if (!fv) begin fv = 1'b1; fp = 8'(p); end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_tbl();
        for (int p = 0; p < 256; p++) begin
            tbl_sel[p] = ($urandom_range(0, 1) == 1);
            tbl_rnd[p] = 8'($urandom);
        end
    endtask

    task automatic pulse_a(input bit mark);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk);
        if (mark) t_a0 = longint'($time);
        #1 start_a = 1'b0;
    endtask

    task automatic pulse_d();
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); t_d0 = longint'($time);
        #1 start_d = 1'b0;
    endtask

    task automatic wait_pat_a(input logic [7:0] p);
        int n = 0;
        while (pat_a !== p && n < 5000) begin @(posedge clk); #1; n++; end
        check("pat_a_reached", 32'(pat_a), 32'(p));
    endtask

    // Waits for done and returns the cycle count from the start edge to DONE entry.
    task automatic wait_done_a(output int cyc);
        int n = 0;
        while (done_a !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
        check("done_a_reached", 32'(done_a), 32'd1);
        cyc = int'((longint'($time) - t_a0) / 10);
    endtask

    task automatic wait_done_d(output int cyc);
        int n = 0;
        while (done_d !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
        check("done_d_reached", 32'(done_d), 32'd1);
        cyc = int'((longint'($time) - t_d0) / 10);
    endtask

    task automatic check_results_a(input string tag, input int n, input logic [7:0] fp, input bit fv);
        check({tag, "_err"},  32'(err_a),  32'(n));
        check({tag, "_fv"},   32'(fv_a),   32'(fv));
        check({tag, "_fp"},   32'(fp_a),   32'(fp));
        check({tag, "_pass"}, 32'(pass_a), 32'(n == 0));
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_pat"},  32'(pat_a),  32'hFF);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_pat"},  32'(pat_a),  32'h00);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_err"},  32'(err_a),  32'd0);
        check({tag, "_fv"},   32'(fv_a),   32'd0);
        check({tag, "_fp"},   32'(fp_a),   32'h00);
    endtask

    initial begin
        int cyc;
        int rn;
        logic [7:0] rfp;
        bit rfv;

        rst = 1'b1; start_a = 1'b0; start_d = 1'b0;
        gen_tbl();
        #1;
        check_reset_a("reset_a");
        check("reset_d_busy", 32'(busy_d), 32'd0);
        check("reset_d_err",  32'(err_d),  32'd0);

        // start together with rst: reset wins, BIST stays idle.
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy", 32'(busy_a), 32'd0);
        check("rst_start_pat",  32'(pat_a),  32'h00);

        // Identity sorter: only the 35 nondecreasing patterns pass.
        mode_a = 1;
        pulse_a(1'b1);
        check("ident_busy_on", 32'(busy_a), 32'd1);
        check("ident_done_off", 32'(done_a), 32'd0);
        wait_done_a(cyc);
        check("ident_cycles", 32'(cyc), 32'd768);
        check_results_a("ident", 221, 8'h04, 1'b1);

        // Stuck-at-zero, started from DONE: results must clear on start.
        mode_a = 2;
        pulse_a(1'b1);
        check("restart_err_clr", 32'(err_a), 32'd0);
        check("restart_fv_clr",  32'(fv_a),  32'd0);
        check("restart_fp_clr",  32'(fp_a),  32'h00);
        check("restart_done",    32'(done_a), 32'd0);
        wait_done_a(cyc);
        check_results_a("stuck0", 255, 8'h01, 1'b1);

        // Correct sorter, again restarted from DONE.
        mode_a = 0;
        pulse_a(1'b1);
        wait_done_a(cyc);
        check("good_cycles", 32'(cyc), 32'd768);
        check_results_a("good", 0, 8'h00, 1'b0);

        // Random mix of sorted and garbage outputs against the reference.
        for (int k = 0; k < 2; k++) begin
            gen_tbl();
            mode_a = 3;
            ref_sweep(3, 1'b0, rn, rfp, rfv);
            pulse_a(1'b1);
            wait_done_a(cyc);
            check_results_a("rand", rn, rfp, rfv);
        end

        // start pulsed while busy at pattern 0x10 is ignored.
        gen_tbl();
        ref_sweep(3, 1'b0, rn, rfp, rfv);
        pulse_a(1'b1);
        wait_pat_a(8'h10);
        pulse_a(1'b0);
        wait_done_a(cyc);
        check("busy_start_cycles", 32'(cyc), 32'd768);
        check_results_a("busy_start", rn, rfp, rfv);

        // Reset at pattern 0x40 of an identity sweep, then a clean random sweep.
        mode_a = 1;
        pulse_a(1'b1);
        wait_pat_a(8'h40);
        #2 rst = 1'b1;
        #1;
        check_reset_a("midrst");
        @(posedge clk); #1 rst = 1'b0;
        gen_tbl();
        mode_a = 3;
        ref_sweep(3, 1'b0, rn, rfp, rfv);
        pulse_a(1'b1);
        wait_done_a(cyc);
        check("post_rst_cycles", 32'(cyc), 32'd768);
        check_results_a("post_rst", rn, rfp, rfv);

        // Descending checker fed a correct ascending sorter: only 00/55/AA/FF pass.
        mode_d = 0;
        pulse_d();
        wait_done_d(cyc);
        check("desc_cycles", 32'(cyc), 32'd1024);
        check("desc_err",  32'(err_d),  32'd252);
        check("desc_fp",   32'(fp_d),   32'h01);
        check("desc_fv",   32'(fv_d),   32'd1);
        check("desc_pass", 32'(pass_d), 32'd0);

        // Descending checker on random outputs.
        gen_tbl();
        mode_d = 3;
        ref_sweep(3, 1'b1, rn, rfp, rfv);
        pulse_d();
        wait_done_d(cyc);
        check("desc_rand_err",  32'(err_d),  32'(rn));
        check("desc_rand_fp",   32'(fp_d),   32'(rfp));
        check("desc_rand_fv",   32'(fv_d),   32'(rfv));
        check("desc_rand_pass", 32'(pass_d), 32'(rn == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
